// File: rtl/platform_field.sv
// Seven-platform position store for Doodle Fall: scrolls one platform per cycle
// after each frame tick, respawns fallen platforms at the top, publishes a frame at once.
module platform_field #(
  parameter int unsigned VTOP  = 31,
  parameter int unsigned VBOT  = 511,
  parameter int unsigned HMIN  = 326,
  parameter int unsigned HSPAN = 224
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [3:0] scroll_amt,
  input  logic       freeze,
  output logic [9:0] p1_vpos,
  output logic [9:0] p2_vpos,
  output logic [9:0] p3_vpos,
  output logic [9:0] p4_vpos,
  output logic [9:0] p5_vpos,
  output logic [9:0] p6_vpos,
  output logic [9:0] p7_vpos,
  output logic [9:0] p1_hpos,
  output logic [9:0] p2_hpos,
  output logic [9:0] p3_hpos,
  output logic [9:0] p4_hpos,
  output logic [9:0] p5_hpos,
  output logic [9:0] p6_hpos,
  output logic [9:0] p7_hpos,
  output logic       frame_done,
  output logic       overrun
);

  localparam logic [9:0] RST_V [7] = '{10'd41, 10'd111, 10'd181, 10'd251, 10'd321, 10'd391, 10'd461};
  localparam logic [9:0] RST_H [7] = '{10'd340, 10'd460, 10'd380, 10'd500, 10'd350, 10'd440, 10'd400};
  localparam logic [9:0]  WRAP      = 10'(VBOT - VTOP + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_accept, w_commit;
  logic [2:0]  r_idx;
  logic [3:0]  r_amt;
  logic [15:0] r_lfsr;
  logic [9:0]  r_v  [7];
  logic [9:0]  r_h  [7];
  logic [9:0]  r_ov [7];
  logic [9:0]  r_oh [7];
  logic        r_done, r_ovr;
  logic [9:0]  w_sum, w_roff, w_hnew;
  logic [7:0]  w_r8;
  logic        w_respawn, w_fb;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: if (frame_tick && !freeze) begin
        w_accept    = 1'b1;
        w_state_nxt = UPDATE;
      end
      UPDATE: if (r_idx == 3'd6) w_state_nxt = COMMIT;
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Respawn column folds the LFSR byte into HSPAN with a single subtract.
  assign w_sum     = r_v[r_idx] + 10'(r_amt);
  assign w_respawn = w_sum > 10'(VBOT);
  assign w_r8      = r_lfsr[7:0];
  assign w_roff    = ({2'b00, w_r8} < 10'(HSPAN)) ? {2'b00, w_r8} : {2'b00, w_r8} - 10'(HSPAN);
  assign w_hnew    = 10'(HMIN) + w_roff;
  assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 7; i++) begin
        r_v[i]  <= RST_V[i];
        r_h[i]  <= RST_H[i];
        r_ov[i] <= RST_V[i];
        r_oh[i] <= RST_H[i];
      end
      r_idx  <= '0;
      r_amt  <= '0;
      r_lfsr <= LFSR_SEED;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (frame_tick && r_state != IDLE) r_ovr <= 1'b1;
      if (w_accept) begin
        r_amt <= scroll_amt;
        r_idx <= '0;
      end
      if (r_state == UPDATE) begin
        r_idx <= r_idx + 3'd1;
        if (w_respawn) begin
          r_v[r_idx] <= w_sum - WRAP;
          r_h[r_idx] <= w_hnew;
          r_lfsr     <= {r_lfsr[14:0], w_fb};
        end else begin
          r_v[r_idx] <= w_sum;
        end
      end
      if (w_commit) begin
        for (int unsigned i = 0; i < 7; i++) begin
          r_ov[i] <= r_v[i];
          r_oh[i] <= r_h[i];
        end
      end
    end
  end

  assign p1_vpos = r_ov[0];
  assign p2_vpos = r_ov[1];
  assign p3_vpos = r_ov[2];
  assign p4_vpos = r_ov[3];
  assign p5_vpos = r_ov[4];
  assign p6_vpos = r_ov[5];
  assign p7_vpos = r_ov[6];
  assign p1_hpos = r_oh[0];
  assign p2_hpos = r_oh[1];
  assign p3_hpos = r_oh[2];
  assign p4_hpos = r_oh[3];
  assign p5_hpos = r_oh[4];
  assign p6_hpos = r_oh[5];
  assign p7_hpos = r_oh[6];
  assign frame_done = r_done;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_platform_field.sv
// Scoreboard bench for platform_field: stimulus pushes expected frames, a monitor
// pops them on frame_done and checks outputs hold steady between commits.
module tb_platform_field;

  logic       pixel_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] scroll_amt = 4'd0;
  logic       freeze = 1'b0;
  logic [9:0] p1_vpos, p2_vpos, p3_vpos, p4_vpos, p5_vpos, p6_vpos, p7_vpos;
  logic [9:0] p1_hpos, p2_hpos, p3_hpos, p4_hpos, p5_hpos, p6_hpos, p7_hpos;
  logic       frame_done, overrun;

  always #20 pixel_clk = ~pixel_clk;

  platform_field #(.VTOP(31), .VBOT(511), .HMIN(326), .HSPAN(224)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .scroll_amt(scroll_amt), .freeze(freeze),
    .p1_vpos(p1_vpos), .p2_vpos(p2_vpos), .p3_vpos(p3_vpos), .p4_vpos(p4_vpos),
    .p5_vpos(p5_vpos), .p6_vpos(p6_vpos), .p7_vpos(p7_vpos),
    .p1_hpos(p1_hpos), .p2_hpos(p2_hpos), .p3_hpos(p3_hpos), .p4_hpos(p4_hpos),
    .p5_hpos(p5_hpos), .p6_hpos(p6_hpos), .p7_hpos(p7_hpos),
    .frame_done(frame_done), .overrun(overrun)
  );

  typedef logic [6:0][9:0] pos_t;
  typedef struct packed {
    pos_t        v;
    pos_t        h;
    int unsigned due;
  } exp_t;

  localparam pos_t RST_V = {10'd461, 10'd391, 10'd321, 10'd251, 10'd181, 10'd111, 10'd41};
  localparam pos_t RST_H = {10'd400, 10'd440, 10'd350, 10'd500, 10'd380, 10'd460, 10'd340};

  exp_t        q[$];
  pos_t        m_v, m_h, cur_v, cur_h, w_v, w_h;
  logic [15:0] m_lfsr;
  logic        exp_ovr = 1'b0;
  int unsigned cyc = 0, total = 0, bad = 0;

  assign w_v = {p7_vpos, p6_vpos, p5_vpos, p4_vpos, p3_vpos, p2_vpos, p1_vpos};
  assign w_h = {p7_hpos, p6_hpos, p5_hpos, p4_hpos, p3_hpos, p2_hpos, p1_hpos};

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int unsigned act, input int unsigned want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d @cyc %0d", nm, act, want, cyc);
    end
  endtask

  // Monitor: pops one expected frame per frame_done, otherwise outputs must hold.
  always @(negedge pixel_clk) begin
    if (!rst_n) begin
      cur_v = RST_V;
      cur_h = RST_H;
    end else begin
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_latency_cyc", cyc, e.due);
          for (int i = 0; i < 7; i++) begin
            chk($sformatf("p%0d_vpos", i + 1), w_v[i], e.v[i]);
            chk($sformatf("p%0d_hpos", i + 1), w_h[i], e.h[i]);
          end
          cur_v = e.v;
          cur_h = e.h;
        end
      end else begin
        total++;
        if ({w_v, w_h} !== {cur_v, cur_h}) begin
          bad++;
          $display("FAIL hold_outputs: got=%h_%h want=%h_%h @cyc %0d", w_v, w_h, cur_v, cur_h, cyc);
        end
      end
      chk("overrun", overrun, exp_ovr);
    end
  end

  task automatic model_reset();
    m_v = RST_V;
    m_h = RST_H;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_pass(input int unsigned a);
    int unsigned s, r;
    for (int i = 0; i < 7; i++) begin
      s = m_v[i] + a;
      if (s > 511) begin
        m_v[i] = 10'(s - 481);
        r = m_lfsr[7:0];
        if (r >= 224) r = r - 224;
        m_h[i] = 10'(326 + r);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end else begin
        m_v[i] = 10'(s);
      end
    end
  endtask

  // mode 0: accepted pass, 1: arrives while busy (overrun), 2: ignored under freeze
  task automatic do_tick(input logic [3:0] a, input int mode);
    exp_t e;
    @(negedge pixel_clk);
    scroll_amt = a;
    frame_tick = 1'b1;
    @(posedge pixel_clk);
    #1;
    frame_tick = 1'b0;
    if (mode == 0) begin
      model_pass(a);
      e.v = m_v;
      e.h = m_h;
      e.due = cyc + 8;
      q.push_back(e);
    end else if (mode == 1) begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge pixel_clk);
    chk("pending_frames", q.size(), 0);
    @(negedge pixel_clk);
  endtask

  task automatic do_reset();
    @(negedge pixel_clk);
    rst_n = 1'b0;
    exp_ovr = 1'b0;
    q.delete();
    model_reset();
    @(negedge pixel_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge pixel_clk);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_p1_vpos", p1_vpos, 41);
    chk("rst_p7_vpos", p7_vpos, 461);
    chk("rst_p4_hpos", p4_hpos, 500);
    chk("rst_p7_hpos", p7_hpos, 400);
    rst_n = 1'b1;

    // single scroll; scroll_amt changes right after the latch cycle
    do_tick(4'd5, 0);
    scroll_amt = 4'd9;
    wait_idle();
    chk("scroll_p1_vpos", p1_vpos, 46);
    chk("scroll_p7_vpos", p7_vpos, 466);
    chk("scroll_p3_hpos", p3_hpos, 380);

    // respawn from the reset layout
    do_reset();
    for (int f = 0; f < 4; f++) begin
      do_tick(4'd15, 0);
      wait_idle();
    end
    chk("resp_p7_vpos", p7_vpos, 40);
    chk("resp_p7_hpos", p7_hpos, 327);
    chk("resp_p1_vpos", p1_vpos, 101);
    chk("resp_p6_vpos", p6_vpos, 451);
    for (int f = 0; f < 5; f++) begin
      do_tick(4'd15, 0);
      wait_idle();
    end
    chk("resp2_p6_vpos", p6_vpos, 45);
    chk("resp2_p6_hpos", p6_hpos, 521);
    chk("resp2_p7_vpos", p7_vpos, 115);
    chk("resp2_p5_vpos", p5_vpos, 456);

    do_tick(4'd0, 0);
    wait_idle();
    chk("zero_p6_vpos", p6_vpos, 45);

    // second tick 3 cycles after the first
    do_tick(4'd7, 0);
    repeat (2) @(posedge pixel_clk);
    do_tick(4'd3, 1);
    wait_idle();
    chk("ovr_flag", overrun, 1);
    chk("ovr_p6_vpos", p6_vpos, 52);

    // frozen tick is ignored
    freeze = 1'b1;
    do_tick(4'd4, 2);
    repeat (12) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("frz_p6_vpos", p6_vpos, 52);
    freeze = 1'b0;

    // freeze raised mid-pass does not abort
    do_tick(4'd4, 0);
    repeat (3) @(posedge pixel_clk);
    #1 freeze = 1'b1;
    wait_idle();
    freeze = 1'b0;
    chk("frzmid_p6_vpos", p6_vpos, 56);

    // reset pulse in the middle of a pass
    do_tick(4'd6, 0);
    repeat (4) @(posedge pixel_clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    model_reset();
    exp_ovr = 1'b0;
    @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("rstmid_p1_vpos", p1_vpos, 41);
    chk("rstmid_p7_hpos", p7_hpos, 400);
    chk("rstmid_overrun", overrun, 0);

    // LFSR must be back at its seed
    for (int f = 0; f < 4; f++) begin
      do_tick(4'd15, 0);
      wait_idle();
    end
    chk("lfsr_p7_hpos", p7_hpos, 327);
    chk("lfsr_p7_vpos", p7_vpos, 40);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/platform_field.md
# platform_field

Owns the positions of the seven Doodle Fall platforms and feeds them to the VGA renderer as `p1..p7_vpos/hpos`. Once per frame it scrolls every platform down by a requested amount. Any platform that leaves the bottom of the playfield respawns at the top with a pseudo-random horizontal position. Outputs are double-buffered so the renderer never sees a half-updated frame.

## Interface
- `VTOP`, default 31: first visible line; same as renderer `vbp`.
- `VBOT`, default 511: last visible line; same as renderer `vfp`.
- `HMIN`, default 326: leftmost legal platform `hpos`; equals renderer `hbp` + 1.
- `HSPAN`, default 224: number of legal `hpos` values, so `hpos` ∈ `HMIN..HMIN+HSPAN-1` (326..549; platform width 75 stays inside 625).
- `pixel_clk`, input, 1: 25 MHz pixel clock; the only clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `frame_tick`, input, 1: one-cycle pulse per frame, driven from the vsync start.
- `scroll_amt`, input, 4: lines to scroll this frame, 0..15, from doodle physics.
- `freeze`, input, 1: game terminated; frame updates are suppressed while high.
- `p1_vpos` … `p7_vpos`, output, 10 each: platform top line, in counter space.
- `p1_hpos` … `p7_hpos`, output, 10 each: platform left column, in counter space.
- `frame_done`, output, 1: one-cycle pulse when the outputs take a new frame.
- `overrun`, output, 1: sticky flag; a `frame_tick` arrived while the block was busy.

## Operation
- **Reset layout** (working and output registers):
  - `vpos` = 41, 111, 181, 251, 321, 391, 461
  - `hpos` = 340, 460, 380, 500, 350, 440, 400
  - `frame_done` = 0, `overrun` = 0, LFSR = 16'hACE1, state = IDLE.
- **LFSR**: 16-bit Fibonacci, shifts left; new LSB = b15^b13^b12^b10. It advances only on a respawn, one step per respawn.
- **FSM states**: IDLE, UPDATE, COMMIT.
  - IDLE: `frame_tick`=1 and `freeze`=0 → latch `scroll_amt` into `amt`, set `idx`=0, go to UPDATE. `frame_tick` with `freeze`=1 is ignored.
  - UPDATE: handles one platform per cycle, `idx` 0..6.
    - `sum = vpos[idx] + amt`, 10-bit; maximum is 511+15 = 526, so no overflow.
    - If `sum` > `VBOT`: respawn. `vpos[idx] = sum - 481` (512 maps to 31), `hpos[idx] = HMIN + r`, then the LFSR advances.
      - `r = L[7:0]` if `L[7:0]` < 224, else `L[7:0] - 224`; `L` is the LFSR value before the advance.
    - Otherwise `vpos[idx] = sum`; `hpos` is unchanged.
    - After `idx`=6, go to COMMIT.
  - COMMIT: copy all 14 working registers to the outputs, pulse `frame_done`, go to IDLE.
- **Invariants**: every `vpos` stays in 31..511 at all times; every `hpos` stays in 326..549.
- **Boundaries**:
  - `frame_tick` in UPDATE or COMMIT sets `overrun`. The tick is otherwise dropped; no queueing.
  - `overrun` clears only on reset.
  - `freeze` rising during UPDATE does not abort; the pass finishes and commits.
  - `scroll_amt` changing after the latch cycle has no effect on the current pass.
  - `scroll_amt`=0 still runs the pass and pulses `frame_done`; positions are unchanged.
  - Platforms are processed in index order, so two respawns in one pass use consecutive LFSR values, p-lower first.
  - `rst_n` low at any time, including mid-UPDATE, immediately restores the reset layout. The outputs never show a partial pass.

## Timing
- `frame_tick` sampled at edge 0 → UPDATE runs on edges 1..7 → COMMIT on edge 8.
- New outputs and `frame_done`=1 are visible after edge 8, for exactly one cycle.
- Total latency: 8 cycles, far below the frame period (416,800 cycles).
- Outputs are registered and change only at COMMIT or reset.
- The renderer samples them combinationally, so changes land during vertical blanking.
- The block accepts one tick per 9 cycles at most; a tick on edges 1..8 sets `overrun` at that edge.

## Test plan
- **Reset**: assert `rst_n`=0 → outputs equal the reset layout; `frame_done`=0, `overrun`=0.
- **Single scroll**: `scroll_amt`=5 with one `frame_tick` → 8 cycles later all `vpos` are +5 (46..466), `hpos` unchanged, and `frame_done` is high for 1 cycle.
- **Respawn**: `scroll_amt`=15 for four frames → after the 4th commit, p7 has `vpos`=40 and `hpos`=327 (0xE1 → 225-224 = 1); p1..p6 have `vpos` +60. LFSR = 16'h59C3.
- **Overrun**: second `frame_tick` 3 cycles after the first → `overrun`=1, only one pass runs, `vpos` moves by `amt` only once.
- **Freeze**: `freeze`=1 with `frame_tick` → no `frame_done`, outputs unchanged. Raise `freeze` at UPDATE `idx`=3 → the pass still commits.
- **Reset mid-pass**: pulse `rst_n` low for 1 cycle at UPDATE `idx`=4 → outputs and LFSR return to their reset values; no `frame_done` follows.
